fp_add_sched: RTL and testbench
===============================

FP_ADD_SCHED -- requirements
Module: fp_add_sched

Interface
REQ-001 Parameter EXEC_CYCLES, default 2, legal range 1..7: the number of cycles the operands are held on the combinational FP adder before its result is sampled.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  the scheduler accepts requester N this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  IEEE-754 single-precision operands.
REQ-007 req0_sub / req1_sub  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-008 fpa_a, fpa_b  output  32  operands driven to the external adder.
REQ-009 fpa_sub  output  1  add/sub select driven to the external adder.
REQ-010 fpa_n  input  32  packed result returned by the external adder.
REQ-011 rsp_valid  output  1  a result is available.
REQ-012 rsp_ready  input  1  the consumer accepts the result.
REQ-013 rsp_n  output  32  the result value.
REQ-014 rsp_id  output  1  the index of the requester that owns the result.
REQ-015 busy  output  1  the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states:
- IDLE: waiting for a request.
- EXEC: waiting out the adder latency.
- RESP: holding the result for the consumer.
REQ-017 In IDLE the grant SHALL be combinational:
- If exactly one requester is valid, that requester is granted.
- If both are valid, the requester not named by last_id is granted.
REQ-018 Exactly the granted requester's ready SHALL be 1 in IDLE; both ready outputs SHALL be 0 in EXEC and RESP.
REQ-019 On the accept edge (valid and ready both high), the block SHALL:
- latch a, b, sub and id into operand registers;
- set last_id to the granted id;
- load the counter with EXEC_CYCLES-1;
- enter EXEC.
REQ-020 fpa_a, fpa_b and fpa_sub SHALL be driven only from the operand registers, so they stay stable from the cycle after acceptance until the return to IDLE.
REQ-021 In EXEC the counter SHALL decrement each cycle. When the counter is 0, fpa_n SHALL be registered into rsp_n and the FSM SHALL enter RESP.
REQ-022 Latency: for an accept edge at the end of cycle T, rsp_valid SHALL first be 1 in cycle T+EXEC_CYCLES+1.
REQ-023 In RESP, rsp_valid SHALL be 1, and rsp_n and rsp_id SHALL stay stable until rsp_ready is sampled 1; on that edge the FSM SHALL return to IDLE.
REQ-024 Only one operation SHALL be outstanding at a time. No request is accepted in the RESP-exit cycle; the earliest next accept is the following cycle.
REQ-025 If a requester drops valid before it is granted, no state change SHALL occur.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 While rst_n is 0, the block SHALL force:
- state = IDLE, last_id = 1, counter = 0;
- operand registers, rsp_n and rsp_id = 0;
- rsp_valid, both ready outputs and busy = 0.
REQ-028 Assertion of rst_n mid-EXEC or mid-RESP SHALL discard the in-flight operation with no response issued. The first post-reset grant with both requesters valid SHALL go to req0.

Configuration
REQ-029 With FP_ADD_SCHED_STATS_EN defined, the block SHALL add two outputs: gnt_cnt0 and gnt_cnt1, each 16 bits.
- Each counts accepted handshakes for its requester.
- Each saturates at 16'hFFFF.
- Each resets to 0.
REQ-030 Without FP_ADD_SCHED_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Single add: req0 with a=0x3F800000, b=0x40000000, sub=0, and EXEC_CYCLES=2 -> rsp_valid exactly 3 cycles after the accept edge, rsp_n=0x40400000, rsp_id=0.
REQ-032 Subtract: req1 with a=0x40400000, b=0x3F800000, sub=1 -> rsp_n=0x40000000, rsp_id=1.
REQ-033 Contention: both requesters held valid for 4 operations -> grant order 0,1,0,1, with at most one ready high per cycle.
REQ-034 Backpressure: rsp_ready held 0 for 10 cycles in RESP -> rsp_n and rsp_id remain stable, both ready outputs remain 0, busy remains 1.
REQ-035 Reset pulse during EXEC -> no rsp_valid is produced, all outputs read 0, and the next contended grant goes to req0.
REQ-036 With FP_ADD_SCHED_STATS_EN defined: 3 req0 and 2 req1 accepts -> gnt_cnt0=3, gnt_cnt1=2. The counters SHALL also be shown to saturate at 0xFFFF, either by preloading them through force or by running 65 536 or more accepts.

Source files
------------

// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - two-requester scheduler in front of a shared combinational FP adder
// Optional feature: define FP_ADD_SCHED_STATS_EN to add per-requester grant counters.
module fp_add_sched #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic [31:0] fpa_a,
  output logic [31:0] fpa_b,
  output logic        fpa_sub,
  input  logic [31:0] fpa_n,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_n,
  output logic        rsp_id,
  output logic        busy
`ifdef FP_ADD_SCHED_STATS_EN
  ,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter reload value: operands sit on the adder for EXEC_CYCLES cycles.
  localparam logic [2:0] CNT_LOAD = 3'(EXEC_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_id;
  logic [2:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        op_id;
  logic        gnt0;
  logic        gnt1;
  logic        acc0;
  logic        acc1;
  logic        accept;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0 = last_id;
      gnt1 = ~last_id;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  // Handshake outputs and status; ready is also held low while reset is asserted.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && gnt0;
    req1_ready = rst_n && (state == IDLE) && gnt1;
    acc0       = req0_ready && req0_valid;
    acc1       = req1_ready && req1_valid;
    accept     = acc0 || acc1;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
    fpa_a      = op_a;
    fpa_b      = op_b;
    fpa_sub    = op_sub;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept -> wait out adder latency -> hold until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, latency countdown and result sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 1'b1;
      cnt     <= 3'd0;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      op_sub  <= 1'b0;
      op_id   <= 1'b0;
      rsp_n   <= 32'd0;
      rsp_id  <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        op_a    <= acc1 ? req1_a : req0_a;
        op_b    <= acc1 ? req1_b : req0_b;
        op_sub  <= acc1 ? req1_sub : req0_sub;
        op_id   <= acc1;
        last_id <= acc1;
        cnt     <= CNT_LOAD;
      end else if (state == EXEC) begin
        if (cnt == 3'd0) begin
          rsp_n  <= fpa_n;
          rsp_id <= op_id;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

`ifdef FP_ADD_SCHED_STATS_EN
  // Saturating count of accepted handshakes per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= 16'd0;
      gnt_cnt1 <= 16'd0;
    end else begin
      if (acc0 && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (acc1 && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_sched.sv
// tb/tb_fp_add_sched.sv - randomized self-checking bench for fp_add_sched
module tb_fp_add_sched;

  localparam int E = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic [31:0] fpa_a, fpa_b, fpa_n;
  logic        fpa_sub;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_n;
  logic        rsp_id;
  logic        busy;
`ifdef FP_ADD_SCHED_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  int   vectors = 0;
  int   errors = 0;
  logic m_last = 1'b1;

  always #5 clk = ~clk;

  fp_add_sched #(.EXEC_CYCLES(E)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_sub(fpa_sub), .fpa_n(fpa_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_n(rsp_n), .rsp_id(rsp_id), .busy(busy)
`ifdef FP_ADD_SCHED_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // Integer-valued single-precision helpers (|value| < 2^23).
  function automatic int f2i(input logic [31:0] f);
    int e, m, mag;
    e = int'(f[30:23]);
    if (e < 127 || e > 150) return 0;
    m = int'({1'b1, f[22:0]});
    mag = m >> (150 - e);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int mag, p;
    logic [31:0] r;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h7FFFFF);
    return r;
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic s);
    return i2f(s ? f2i(a) - f2i(b) : f2i(a) + f2i(b));
  endfunction

  function automatic int rnd_val();
    return int'($urandom_range(2000)) - 1000;
  endfunction

  // External combinational adder.
  assign fpa_n = fadd(fpa_a, fpa_b, fpa_sub);

  task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
    end
  endtask

  // Drive one request to acceptance and wait for its response; optionally consume it.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit consume, output bit ok, output int lat,
                       output logic [31:0] n, output logic nid);
    ok = 0; lat = 0; n = '0; nid = 1'b0;
    set_req(id, 1'b1, a, b, s);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b, s);
    if (!ok) return;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      n = rsp_n;
      nid = rsp_id;
      if (consume) begin
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0000)
      begin errors++; $display("FAIL reset_ctrl got=%b want=0000", {req0_ready, req1_ready, busy, rsp_valid}); end
    vectors++;
    if (fpa_a !== 32'd0 || fpa_b !== 32'd0 || fpa_sub !== 1'b0 || rsp_n !== 32'd0 || rsp_id !== 1'b0)
      begin errors++; $display("FAIL reset_data fpa_a=%h rsp_n=%h rsp_id=%b want zeros", fpa_a, rsp_n, rsp_id); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic test_single_add();
    bit ok; int lat; logic [31:0] n; logic nid;
    do_op(0, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, ok, lat, n, nid);
    m_last = 1'b0;
    vectors++;
    if (!ok) begin errors++; $display("FAIL add_timeout got=no response want=response"); end
    vectors++;
    if (lat != E + 1) begin errors++; $display("FAIL add_latency got=%0d want=%0d", lat, E + 1); end
    vectors++;
    if (n !== 32'h40400000 || nid !== 1'b0)
      begin errors++; $display("FAIL add_result got=%h/%b want=40400000/0", n, nid); end
  endtask

  task automatic test_subtract();
    bit ok; int lat; logic [31:0] n; logic nid;
    do_op(1, 32'h40400000, 32'h3F800000, 1'b1, 1'b1, ok, lat, n, nid);
    m_last = 1'b1;
    vectors++;
    if (!ok || n !== 32'h40000000 || nid !== 1'b1)
      begin errors++; $display("FAIL sub_result ok=%0d got=%h/%b want=40000000/1", ok, n, nid); end
  endtask

  task automatic test_contention();
    logic [31:0] ca [2];
    logic [31:0] cb [2];
    logic        cs [2];
    logic [31:0] exp_q [$];
    logic        id_q [$];
    int got, done, gi;
    bit acc;
    for (int i = 0; i < 2; i++) begin
      ca[i] = i2f(rnd_val()); cb[i] = i2f(rnd_val()); cs[i] = 1'($urandom_range(1));
      set_req(i, 1'b1, ca[i], cb[i], cs[i]);
    end
    got = 0; done = 0; gi = 0;
    for (int c = 0; c < 200 && done < 4; c++) begin
      @(negedge clk);
      acc = 0;
      vectors++;
      if (req0_ready && req1_ready) begin errors++; $display("FAIL cont_one_ready got=11 want=at most one"); end
      if (req0_ready || req1_ready) begin
        gi = req1_ready ? 1 : 0;
        vectors++;
        if (gi != ((m_last == 1'b1) ? 0 : 1))
          begin errors++; $display("FAIL cont_grant_order got=%0d want=%0d", gi, (m_last == 1'b1) ? 0 : 1); end
        exp_q.push_back(fadd(ca[gi], cb[gi], cs[gi]));
        id_q.push_back(1'(gi));
        m_last = 1'(gi);
        got++;
        acc = 1;
      end
      if (rsp_valid && exp_q.size() > 0) begin
        vectors++;
        if (rsp_n !== exp_q[0] || rsp_id !== id_q[0])
          begin errors++; $display("FAIL cont_result got=%h/%b want=%h/%b", rsp_n, rsp_id, exp_q[0], id_q[0]); end
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
        done++;
      end
      rsp_ready = rsp_valid;
      @(posedge clk); #1;
      if (acc) begin
        ca[gi] = i2f(rnd_val()); cb[gi] = i2f(rnd_val()); cs[gi] = 1'($urandom_range(1));
        set_req(gi, 1'b1, ca[gi], cb[gi], cs[gi]);
      end
      if (got >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    vectors++;
    if (done != 4) begin errors++; $display("FAIL cont_timeout got=%0d want=4 responses", done); end
  endtask

  task automatic test_backpressure();
    bit ok, bad; int lat; logic [31:0] n; logic nid;
    do_op(0, i2f(7), i2f(-5), 1'b0, 1'b0, ok, lat, n, nid);
    m_last = 1'b0;
    vectors++;
    if (!ok) begin errors++; $display("FAIL bp_timeout got=no response want=response"); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_n !== i2f(2) || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b n=%h id=%b r=%b%b busy=%b want v=1 n=%h id=0 r=00 busy=1",
                 c, rsp_valid, rsp_n, rsp_id, req0_ready, req1_ready, busy, i2f(2));
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL bp_release got busy=%b v=%b want 0/0", busy, rsp_valid); end
  endtask

  task automatic test_random();
    int phase;
    logic [31:0] ma, mb, mres;
    logic ms, mid;
    bit e0, e1;
    phase = 0; ma = '0; mb = '0; ms = 1'b0; mres = '0; mid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e0 = 0; e1 = 0;
      if (phase == 0) begin
        if (req0_valid && req1_valid) begin e0 = (m_last == 1'b1); e1 = !e0; end
        else begin e0 = req0_valid; e1 = req1_valid; end
      end
      vectors++;
      if (req0_ready !== e0 || req1_ready !== e1)
        begin errors++; $display("FAIL rand_ready cyc=%0d got=%b%b want=%b%b", c, req0_ready, req1_ready, e0, e1); end
      vectors++;
      if (busy !== (phase != 0) || rsp_valid !== (phase == E + 1))
        begin errors++; $display("FAIL rand_status cyc=%0d got busy=%b v=%b want phase=%0d", c, busy, rsp_valid, phase); end
      if (phase >= 1) begin
        vectors++;
        if (fpa_a !== ma || fpa_b !== mb || fpa_sub !== ms)
          begin errors++; $display("FAIL rand_operands cyc=%0d got=%h %h %b want=%h %h %b", c, fpa_a, fpa_b, fpa_sub, ma, mb, ms); end
      end
      if (phase == E + 1) begin
        vectors++;
        if (rsp_n !== mres || rsp_id !== mid)
          begin errors++; $display("FAIL rand_result cyc=%0d got=%h/%b want=%h/%b", c, rsp_n, rsp_id, mres, mid); end
      end
      if (e0 || e1) begin
        mid = e1;
        ma = e1 ? req1_a : req0_a;
        mb = e1 ? req1_b : req0_b;
        ms = e1 ? req1_sub : req0_sub;
        mres = fadd(ma, mb, ms);
        m_last = mid;
        phase = 1;
      end else if (phase >= 1 && phase <= E) begin
        phase++;
      end else if (phase == E + 1 && rsp_ready) begin
        phase = 0;
      end
      @(posedge clk); #1;
      set_req(0, 1'($urandom_range(1)), i2f(rnd_val()), i2f(rnd_val()), 1'($urandom_range(1)));
      set_req(1, 1'($urandom_range(1)), i2f(rnd_val()), i2f(rnd_val()), 1'($urandom_range(1)));
      rsp_ready = ($urandom_range(2) == 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (E + 3) begin @(posedge clk); #1; end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    bit ok, seen; int lat; logic [31:0] n; logic nid;
    ok = 0;
    set_req(1, 1'b1, i2f(100), i2f(1), 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_ready || req0_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vectors++;
    if (!ok || busy !== 1'b1) begin errors++; $display("FAIL rexec_enter got busy=%b want=1", busy); end
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id} !== 5'b00000 || rsp_n !== 32'd0 ||
        fpa_a !== 32'd0 || fpa_b !== 32'd0 || fpa_sub !== 1'b0)
      begin errors++; $display("FAIL rexec_outputs got ctrl=%b rsp_n=%h fpa_a=%h want zeros",
                               {req0_ready, req1_ready, busy, rsp_valid, rsp_id}, rsp_n, fpa_a); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1; end
    vectors++;
    if (seen) begin errors++; $display("FAIL rexec_no_rsp got=rsp_valid want=none"); end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      begin errors++; $display("FAIL rexec_first_grant got=%b%b want=10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    do_op(0, i2f(9), i2f(4), 1'b1, 1'b1, ok, lat, n, nid);
    m_last = 1'b0;
    vectors++;
    if (!ok || n !== i2f(5) || nid !== 1'b0)
      begin errors++; $display("FAIL rexec_after got=%h/%b want=%h/0", n, nid, i2f(5)); end
  endtask

`ifdef FP_ADD_SCHED_STATS_EN
  task automatic test_stats();
    bit ok; int lat; logic [31:0] n; logic nid;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = 1'b1;
    vectors++;
    if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0)
      begin errors++; $display("FAIL stats_reset got=%h/%h want=0/0", gnt_cnt0, gnt_cnt1); end
    for (int i = 0; i < 5; i++) do_op((i < 3) ? 0 : 1, i2f(i), i2f(1), 1'b0, 1'b1, ok, lat, n, nid);
    vectors++;
    if (gnt_cnt0 !== 16'd3 || gnt_cnt1 !== 16'd2)
      begin errors++; $display("FAIL stats_count got=%0d/%0d want=3/2", gnt_cnt0, gnt_cnt1); end
    force dut.gnt_cnt0 = 16'hFFFE;
    #1;
    release dut.gnt_cnt0;
    for (int i = 0; i < 2; i++) do_op(0, i2f(1), i2f(1), 1'b0, 1'b1, ok, lat, n, nid);
    m_last = 1'b0;
    vectors++;
    if (gnt_cnt0 !== 16'hFFFF || gnt_cnt1 !== 16'd2)
      begin errors++; $display("FAIL stats_saturate got=%h/%0d want=FFFF/2", gnt_cnt0, gnt_cnt1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_contention();
    test_backpressure();
    test_random();
    test_reset_exec();
`ifdef FP_ADD_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
